// File: rtl/int_iq_free_list_mp.sv
// Multi-port free-index list for the integer issue queue.
// Zero-latency peek on the read ports, compacted pushes, and sticky overflow/underflow flags.
module int_iq_free_list_mp #(
  parameter int unsigned ENTRY_W        = 5,
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned PRELOAD_BASE   = 0,
  parameter int unsigned PRELOAD_STRIDE = 4,
  parameter int unsigned RD_PORTS       = 2,
  parameter int unsigned WR_PORTS       = 2
) (
  input  logic                          Clk,
  input  logic                          Rest,
  input  logic [RD_PORTS-1:0]           RdReq,
  output logic [RD_PORTS*ENTRY_W-1:0]   RdData,
  output logic [RD_PORTS-1:0]           RdAvail,
  input  logic [WR_PORTS-1:0]           WrReq,
  input  logic [WR_PORTS*ENTRY_W-1:0]   WrData,
  input  logic                          CriqClean,
  output logic [$clog2(DEPTH):0]        Count,
  output logic                          CriqEmpty,
  output logic                          CriqFull,
  output logic                          ErrOvf,
  output logic                          ErrUdf
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  function automatic logic [ENTRY_W-1:0] preload(input int unsigned i);
    return ENTRY_W'(PRELOAD_BASE + i * PRELOAD_STRIDE);
  endfunction

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]    count_q, count_d;
  logic               ovf_q, ovf_d, udf_q, udf_d;

  logic [CntW-1:0]    n_pop, n_push, free_slots;
  logic               pop_run, udf_hit, ovf_hit;
  logic [WR_PORTS-1:0] wr_acc;
  logic [PtrW-1:0]    wr_idx [WR_PORTS];

  always_comb begin
    n_pop   = '0;
    pop_run = 1'b1;
    udf_hit = 1'b0;
    // Accept only the leading run of requests that have data; anything past it is an error.
    for (int unsigned k = 0; k < RD_PORTS; k++) begin
      if (pop_run && RdReq[k] && (count_q > CntW'(k))) begin
        n_pop = n_pop + CntW'(1);
      end else begin
        pop_run = 1'b0;
        if (RdReq[k]) udf_hit = 1'b1;
      end
    end

    // Free space uses pre-pop occupancy: no same-cycle credit from pops.
    free_slots = CntW'(DEPTH) - count_q;
    n_push     = '0;
    ovf_hit    = 1'b0;
    for (int unsigned w = 0; w < WR_PORTS; w++) begin
      wr_acc[w] = 1'b0;
      wr_idx[w] = tail_q + n_push[PtrW-1:0];
      if (WrReq[w]) begin
        if (n_push < free_slots) begin
          wr_acc[w] = 1'b1;
          n_push    = n_push + CntW'(1);
        end else begin
          ovf_hit = 1'b1;
        end
      end
    end

    head_d  = head_q + n_pop[PtrW-1:0];
    tail_d  = tail_q + n_push[PtrW-1:0];
    count_d = count_q - n_pop + n_push;
    ovf_d   = ovf_q | ovf_hit;
    udf_d   = udf_q | udf_hit;

    if (CriqClean) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = CntW'(DEPTH);
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= preload(i);
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= CntW'(DEPTH);
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      if (CriqClean) begin
        for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= preload(i);
      end else begin
        for (int unsigned w = 0; w < WR_PORTS; w++) begin
          if (wr_acc[w]) mem_q[wr_idx[w]] <= WrData[w*ENTRY_W +: ENTRY_W];
        end
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < RD_PORTS; k++) begin
      RdData[k*ENTRY_W +: ENTRY_W] = mem_q[head_q + PtrW'(k)];
      RdAvail[k]                   = count_q > CntW'(k);
    end
  end

  assign Count     = count_q;
  assign CriqEmpty = (count_q == '0);
  assign CriqFull  = (count_q == CntW'(DEPTH));
  assign ErrOvf    = ovf_q;
  assign ErrUdf    = udf_q;

endmodule

// File: tb/tb_int_iq_free_list_mp.sv
// Directed bench for int_iq_free_list_mp: a queue of expected free indices is filled by pushes
// and drained by pops, and compared against the DUT peek ports and status outputs.
module tb_int_iq_free_list_mp;

  localparam int unsigned EW = 5;
  localparam int unsigned D  = 8;

  logic           Clk = 1'b0;
  logic           Rest;
  logic [1:0]     RdReq;
  logic [2*EW-1:0] RdData;
  logic [1:0]     RdAvail;
  logic [1:0]     WrReq;
  logic [2*EW-1:0] WrData;
  logic           CriqClean;
  logic [3:0]     Count;
  logic           CriqEmpty, CriqFull, ErrOvf, ErrUdf;

  int checks = 0;
  int errors = 0;

  int sb[$];
  logic exp_ovf, exp_udf;

  int_iq_free_list_mp #(
    .ENTRY_W(EW), .DEPTH(D), .PRELOAD_BASE(0), .PRELOAD_STRIDE(4), .RD_PORTS(2), .WR_PORTS(2)
  ) dut (
    .Clk(Clk), .Rest(Rest), .RdReq(RdReq), .RdData(RdData), .RdAvail(RdAvail),
    .WrReq(WrReq), .WrData(WrData), .CriqClean(CriqClean), .Count(Count),
    .CriqEmpty(CriqEmpty), .CriqFull(CriqFull), .ErrOvf(ErrOvf), .ErrUdf(ErrUdf)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    for (int i = 0; i < int'(D); i++) sb.push_back((i * 4) % 32);
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
  endtask

  task automatic check_status(input string tag);
    check({tag, ".count"}, int'(Count), sb.size());
    check({tag, ".full"},  int'(CriqFull), int'(sb.size() == int'(D)));
    check({tag, ".empty"}, int'(CriqEmpty), int'(sb.size() == 0));
    check({tag, ".ovf"},   int'(ErrOvf), int'(exp_ovf));
    check({tag, ".udf"},   int'(ErrUdf), int'(exp_udf));
  endtask

  task automatic check_peek(input string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s.avail%0d", tag, k), int'(RdAvail[k]), int'(sb.size() > k));
      if (sb.size() > k) check($sformatf("%s.data%0d", tag, k), int'(RdData[k*EW +: EW]), sb[k]);
    end
  endtask

  // Called on a falling edge; drives one cycle of stimulus and checks peek then status.
  task automatic step(input string tag, input logic [1:0] rr, input logic [1:0] wr,
                      input int d0, input int d1, input logic cl);
    int npop, nfree, j, sz;
    bit run;
    RdReq = rr; WrReq = wr; WrData = {EW'(d1), EW'(d0)}; CriqClean = cl;
    #1;
    check_peek(tag);
    if (cl) begin
      model_reset();
    end else begin
      sz = sb.size();
      npop = 0; run = 1'b1;
      for (int k = 0; k < 2; k++) begin
        if (run && rr[k] && k < sz) npop++;
        else begin run = 1'b0; if (rr[k]) exp_udf = 1'b1; end
      end
      nfree = int'(D) - sz;
      j = 0;
      for (int w = 0; w < 2; w++) begin
        if (wr[w]) begin
          if (j < nfree) begin sb.push_back(((w == 0) ? d0 : d1) % 32); j++; end
          else exp_ovf = 1'b1;
        end
      end
      for (int k = 0; k < npop; k++) void'(sb.pop_front());
    end
    @(posedge Clk); #1;
    check_status(tag);
    RdReq = '0; WrReq = '0; WrData = '0; CriqClean = 1'b0;
    @(negedge Clk);
  endtask

  initial begin
    Rest = 1'b0; RdReq = '0; WrReq = '0; WrData = '0; CriqClean = 1'b0;
    model_reset();
    repeat (2) @(negedge Clk);
    Rest = 1'b1;
    #1;
    check("rst.count", int'(Count), 8);
    check("rst.full", int'(CriqFull), 1);
    check("rst.data0", int'(RdData[0 +: EW]), 0);
    check("rst.data1", int'(RdData[EW +: EW]), 4);
    check("rst.avail", int'(RdAvail), 3);
    check("rst.ovf", int'(ErrOvf), 0);
    check("rst.udf", int'(ErrUdf), 0);
    @(negedge Clk);

    // Dual pops drain 0,4 / 8,12 / 16,20.
    step("pop_a", 2'b11, 2'b00, 0, 0, 1'b0);
    step("pop_b", 2'b11, 2'b00, 0, 0, 1'b0);
    step("pop_c", 2'b11, 2'b00, 0, 0, 1'b0);
    check("pop.count2", int'(Count), 2);
    // Pops 24,28 while port 1 alone pushes 5 into the first free slot.
    step("popush", 2'b11, 2'b10, 0, 5, 1'b0);
    check("compact.data0", int'(RdData[0 +: EW]), 5);
    check("compact.avail", int'(RdAvail), 1);

    step("gap", 2'b10, 2'b00, 0, 0, 1'b0);
    check("gap.udf", int'(ErrUdf), 1);
    step("udf", 2'b11, 2'b00, 0, 0, 1'b0);
    check("udf.empty", int'(CriqEmpty), 1);

    for (int i = 0; i < 4; i++) step($sformatf("fill%0d", i), 2'b00, 2'b11, 2*i + 7, 2*i + 8, 1'b0);
    check("fill.full", int'(CriqFull), 1);
    step("ovf", 2'b00, 2'b01, 30, 0, 1'b0);
    check("ovf.flag", int'(ErrOvf), 1);
    step("ovf_hold", 2'b01, 2'b00, 0, 0, 1'b0);

    for (int i = 1; i <= 16; i++) begin
      step($sformatf("wrap_pop%0d", i), 2'b01, 2'b00, 0, 0, 1'b0);
      step($sformatf("wrap_push%0d", i), 2'b00, 2'b01, i % 32, 0, 1'b0);
    end

    step("clean", 2'b11, 2'b01, 9, 0, 1'b1);
    check("clean.count", int'(Count), 8);
    check("clean.ovf", int'(ErrOvf), 0);
    step("after_clean", 2'b11, 2'b00, 0, 0, 1'b0);

    // Asynchronous reset mid-operation.
    RdReq = 2'b01;
    #2;
    Rest = 1'b0;
    #1;
    check("arst.count", int'(Count), 8);
    check("arst.data0", int'(RdData[0 +: EW]), 0);
    check("arst.data1", int'(RdData[EW +: EW]), 4);
    RdReq = '0;
    @(negedge Clk);
    Rest = 1'b1;
    model_reset();
    step("post_arst", 2'b11, 2'b00, 0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/int_iq_free_list_mp.md
Name: int_iq_free_list_mp

Overview:
- Multi-port free-index list for the integer issue queue. Successor to the single-port 8-deep index queue.
- Holds the IQ entry indices that are currently free. Dispatch pops up to RD_PORTS indices per cycle; issue/retire pushes up to WR_PORTS released indices per cycle.
- Reset and flush preload an arithmetic index pattern. Occupancy, full/empty and sticky error flags are exported to dispatch stall logic.

Parameters:
- ENTRY_W, 5, width of one stored index.
- DEPTH, 8, number of storage slots; a power of two, 2..64.
- PRELOAD_BASE, 0, index preloaded into slot 0.
- PRELOAD_STRIDE, 4, increment between preloaded slots; slot i = PRELOAD_BASE + i*PRELOAD_STRIDE, truncated to ENTRY_W.
- RD_PORTS, 2, pop ports per cycle, 1..4, must be <= DEPTH.
- WR_PORTS, 2, push ports per cycle, 1..4, must be <= DEPTH.

Ports:
- Clk  in  1  clock, rising edge.
- Rest  in  1  asynchronous active-low reset.
- RdReq  in  RD_PORTS  pop request per port.
- RdData  out  RD_PORTS*ENTRY_W  peek data; port k occupies bits [k*ENTRY_W +: ENTRY_W].
- RdAvail  out  RD_PORTS  port k has a valid entry.
- WrReq  in  WR_PORTS  push request per port.
- WrData  in  WR_PORTS*ENTRY_W  push data, same packing as RdData.
- CriqClean  in  1  synchronous flush back to the preload state.
- Count  out  $clog2(DEPTH)+1  current occupancy.
- CriqEmpty  out  1  Count == 0.
- CriqFull  out  1  Count == DEPTH.
- ErrOvf  out  1  sticky: a push was dropped.
- ErrUdf  out  1  sticky: pop requested without RdAvail, or RdReq was not a thermometer code.

Behaviour:
- State:
  - Storage array of DEPTH entries.
  - Head and tail pointers, each $clog2(DEPTH) bits; wrap is natural modulo DEPTH.
  - Count register; full and empty are distinguished by Count.
- Reset (Rest low, asynchronous):
  - Slot i = preload value; head = 0; tail = 0; Count = DEPTH.
  - CriqFull = 1, CriqEmpty = 0, ErrOvf = 0, ErrUdf = 0.
- Read side (combinational peek, zero latency):
  - RdData[k] = slot[head+k]; RdAvail[k] = (Count > k).
  - RdData of an unavailable port is don't-care.
- Pop acceptance:
  - Accepted pops = longest prefix of RdReq ones starting at port 0, limited to Count.
  - Head advances by that number and Count decreases by it, at the clock edge.
  - If any RdReq bit is set above the accepted prefix, ErrUdf is set. This covers a gap (non-thermometer code) or an underflow.
- Push side:
  - Requesting ports are compacted in ascending port order. The j-th requester writes slot[tail+j].
  - Free space = DEPTH - Count, using Count before this cycle's pops. No same-cycle pop-to-push credit.
  - Requesters beyond free space are dropped and ErrOvf is set.
  - Tail advances by the number of accepted pushes.
- Simultaneous pop and push:
  - Next Count = Count - pops + pushes.
  - Pushed data is not visible on RdData until the following cycle; there is no bypass.
- CriqClean:
  - Highest priority. Same-cycle pops and pushes are ignored.
  - Next state equals the reset state, including clearing the error flags.
- Flags:
  - Error flags hold until reset or CriqClean.
  - Count, CriqEmpty and CriqFull come directly from registered Count. No extra cycle.
- Reset mid-operation overrides everything immediately. Outputs show the reset values while Rest is low.

Test Plan:
- Reset release, defaults -> Count=8, CriqFull=1, RdData port0=0, port1=4, RdAvail=2'b11, both error flags 0.
- RdReq=2'b11 for 3 cycles -> popped indices 0,4 / 8,12 / 16,20; Count=2; next peek shows 24,28.
- From Count=2: RdReq=2'b11 plus WrReq=2'b10 with WrData port1=5 -> Count=1; next cycle port0=5, RdAvail=2'b01. Verifies compaction and no bypass.
- From full: WrReq=2'b01 -> push dropped, ErrOvf=1, Count stays 8. Then pop one index -> ErrOvf remains 1.
- RdReq=2'b10 (gap) -> no pop, ErrUdf=1. RdReq=2'b11 at Count=1 -> one pop, ErrUdf=1.
- Wrap: 16 alternating pop-1/push-1 cycles pushing values 1..16 (truncated to ENTRY_W) -> FIFO order preserved across wrap. Then CriqClean together with RdReq=2'b11 -> preload state restored, Count=8, errors cleared.
